// File: rtl/display_mode_ctrl.sv
// Display mode sequencer: steps the pattern-generator mode on key pulses or on a
// timed auto-advance, committing the new mode only at a frame boundary.
module display_mode_ctrl #(
  parameter logic [27:0] PIXEL_FREQUENCY = 28'd108_000_000,
  parameter logic [4:0]  DELAY           = 5'd3,
  parameter logic [3:0]  NUM_MODES       = 4'd8
) (
  input  logic       clk_vga_display,
  input  logic       rst_n_display,
  input  logic       frame_start_display,
  input  logic       key_next_display,
  input  logic       key_prev_display,
  input  logic       key_pause_display,
  output logic [2:0] mode_display,
  output logic       auto_display,
  output logic       pending_display,
  output logic       sec_tick_display
);

  localparam logic [27:0] PRESC_MAX = PIXEL_FREQUENCY - 28'd1;
  localparam logic [4:0]  DWELL_MAX = DELAY - 5'd1;
  localparam logic [3:0]  NM_M1     = NUM_MODES - 4'd1;
  localparam logic [2:0]  MODE_MAX  = NM_M1[2:0];

  typedef enum logic {S_AUTO = 1'b0, S_HOLD = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [27:0] presc_q, presc_d;
  logic [4:0]  dwell_q, dwell_d;
  logic [2:0]  target_q, target_d;
  logic [2:0]  mode_q, mode_d;
  logic        pending_q, pending_d;
  logic        tick_q, tick_d;
  logic        sec_evt, auto_req, enter_auto, step_up, step_dn;

  always_ff @(posedge clk_vga_display or negedge rst_n_display) begin
    if (!rst_n_display) begin
      state_q   <= S_AUTO;
      presc_q   <= '0;
      dwell_q   <= '0;
      target_q  <= '0;
      mode_q    <= '0;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      dwell_q   <= dwell_d;
      target_q  <= target_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (key_pause_display)
      state_d = (state_q == S_AUTO) ? S_HOLD : S_AUTO;
    enter_auto = key_pause_display && (state_q == S_HOLD);

    // The dwell counter advances on the same edge that raises sec_tick_display.
    sec_evt = (presc_q == PRESC_MAX);
    tick_d  = sec_evt;
    presc_d = sec_evt ? 28'd0 : presc_q + 28'd1;
    if (enter_auto)
      presc_d = '0;

    auto_req = (state_q == S_AUTO) && sec_evt && (dwell_q == DWELL_MAX);
    dwell_d  = dwell_q;
    if ((state_q == S_AUTO) && sec_evt)
      dwell_d = auto_req ? 5'd0 : dwell_q + 5'd1;
    if ((state_q == S_HOLD) || (state_d == S_HOLD) || key_next_display || key_prev_display)
      dwell_d = '0;

    // Keys win over the auto request; opposing keys cancel everything.
    step_up = (key_next_display && !key_prev_display) ||
              (!key_next_display && !key_prev_display && auto_req);
    step_dn = key_prev_display && !key_next_display;

    target_d = target_q;
    if (step_up)
      target_d = (target_q == MODE_MAX) ? 3'd0 : target_q + 3'd1;
    else if (step_dn)
      target_d = (target_q == 3'd0) ? MODE_MAX : target_q - 3'd1;

    // Commit uses the registered target, so a same-cycle request waits a frame.
    mode_d    = frame_start_display ? target_q : mode_q;
    pending_d = (target_d != mode_d);
  end

  assign mode_display     = mode_q;
  assign auto_display     = (state_q == S_AUTO);
  assign pending_display  = pending_q;
  assign sec_tick_display = tick_q;

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Directed bench for display_mode_ctrl: expectations queued per step, popped and
// asserted once the DUT outputs have settled after the clock edge.
module tb_display_mode_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame = 1'b0, knext = 1'b0, kprev = 1'b0, kpause = 1'b0;

  logic [2:0] mode8, mode5;
  logic       auto8, auto5, pend8, pend5, tick8, tick5;

  always #5 clk = ~clk;

  display_mode_ctrl #(.PIXEL_FREQUENCY(28'd4), .DELAY(5'd2), .NUM_MODES(4'd8)) dut8 (
    .clk_vga_display(clk), .rst_n_display(rst_n), .frame_start_display(frame),
    .key_next_display(knext), .key_prev_display(kprev), .key_pause_display(kpause),
    .mode_display(mode8), .auto_display(auto8), .pending_display(pend8),
    .sec_tick_display(tick8));

  display_mode_ctrl #(.PIXEL_FREQUENCY(28'd4), .DELAY(5'd2), .NUM_MODES(4'd5)) dut5 (
    .clk_vga_display(clk), .rst_n_display(rst_n), .frame_start_display(frame),
    .key_next_display(knext), .key_prev_display(kprev), .key_pause_display(kpause),
    .mode_display(mode5), .auto_display(auto5), .pending_display(pend5),
    .sec_tick_display(tick5));

  typedef struct { string tag; int sel; logic [7:0] val; } exp_t;
  exp_t sb[$];
  int total = 0, passes = 0, fails = 0;
  int lat = 0;

  localparam int M8 = 0, P8 = 1, A8 = 2, T8 = 3, M5 = 4, LAT = 5;

  function automatic logic [7:0] observe(int sel);
    case (sel)
      M8:      return {5'd0, mode8};
      P8:      return {7'd0, pend8};
      A8:      return {7'd0, auto8};
      T8:      return {7'd0, tick8};
      M5:      return {5'd0, mode5};
      default: return lat[7:0];
    endcase
  endfunction

  task automatic chk(input string tag, input int sel, input logic [7:0] val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [7:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      total++;
      assert (obs === e.val) passes++;
      else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input logic nx, input logic pv, input logic pa, input logic fs);
    knext = nx; kprev = pv; kpause = pa; frame = fs;
    @(posedge clk); #1;
    knext = 1'b0; kprev = 1'b0; kpause = 1'b0; frame = 1'b0;
  endtask

  initial begin
    // reset state
    idle(2);
    chk("rst_mode", M8, 8'd0); chk("rst_pend", P8, 8'd0);
    chk("rst_auto", A8, 8'd1); chk("rst_tick", T8, 8'd0);
    drain();
    rst_n = 1'b1;

    // auto cycling: ticks every 4 cycles, request on the 2nd tick
    idle(3);
    chk("tick_e3", T8, 8'd0); drain();
    idle(1);
    chk("tick_e4", T8, 8'd1); chk("pend_e4", P8, 8'd0); drain();
    idle(1);
    chk("tick_e5", T8, 8'd0); drain();
    idle(3);
    chk("tick_e8", T8, 8'd1); chk("pend_e8", P8, 8'd1); chk("mode_e8", M8, 8'd0); drain();
    pulse(0, 0, 0, 1);
    chk("auto_commit", M8, 8'd1); chk("auto_commit_pend", P8, 8'd0); drain();

    // pause: no change for 100 cycles
    pulse(0, 0, 1, 0);
    chk("pause_auto", A8, 8'd0); drain();
    for (int i = 0; i < 100; i++) begin
      if (i % 20 == 0) pulse(0, 0, 0, 1); else idle(1);
      chk("hold_mode", M8, 8'd1); chk("hold_pend", P8, 8'd0); drain();
    end

    // wrap both directions, NUM_MODES 8 and 5
    pulse(0, 1, 0, 0);
    chk("prev_pend", P8, 8'd1); chk("prev_mode", M8, 8'd1); drain();
    pulse(0, 0, 0, 1);
    chk("to_zero", M8, 8'd0); drain();
    pulse(0, 1, 0, 0);
    pulse(0, 0, 0, 1);
    chk("wrap_dn8", M8, 8'd7); chk("wrap_dn5", M5, 8'd4); chk("wrap_pend", P8, 8'd0); drain();
    pulse(1, 0, 0, 0);
    chk("wrap_up_pend", P8, 8'd1); drain();
    pulse(0, 0, 0, 1);
    chk("wrap_up8", M8, 8'd0); chk("wrap_up5", M5, 8'd0); drain();

    // reach mode 2, then next/prev cancel, then accumulation
    pulse(1, 0, 0, 0); pulse(1, 0, 0, 0); pulse(0, 0, 0, 1);
    chk("mode2", M8, 8'd2); drain();
    pulse(1, 0, 0, 0);
    chk("np_pend1", P8, 8'd1); drain();
    pulse(0, 1, 0, 0);
    chk("np_pend0", P8, 8'd0); chk("np_mode", M8, 8'd2); drain();
    pulse(0, 0, 0, 1);
    chk("np_commit", M8, 8'd2); drain();
    pulse(1, 0, 0, 0);
    chk("acc_pend_a", P8, 8'd1); drain();
    idle(1);
    chk("acc_pend_b", P8, 8'd1); drain();
    pulse(1, 0, 0, 0);
    chk("acc_mode_pre", M8, 8'd2); drain();
    pulse(0, 0, 0, 1);
    chk("acc_commit", M8, 8'd4); chk("acc_pend", P8, 8'd0); drain();
    pulse(1, 1, 0, 0);
    chk("both_keys_pend", P8, 8'd0); drain();

    // request coincident with frame_start commits only at the next frame
    pulse(1, 0, 0, 1);
    chk("same_frame_mode", M8, 8'd4); chk("same_frame_pend", P8, 8'd1); drain();
    pulse(0, 0, 0, 1);
    chk("next_frame_mode", M8, 8'd5); drain();

    // resume: first auto request DELAY*PIXEL_FREQUENCY cycles after entering AUTO
    pulse(0, 0, 1, 0);
    chk("resume_auto", A8, 8'd1); chk("resume_pend", P8, 8'd0); drain();
    lat = 99;
    for (int n = 1; n <= 30; n++) begin
      idle(1);
      if (pend8) begin lat = n; break; end
    end
    chk("resume_latency", LAT, 8'd8); drain();
    pulse(0, 0, 0, 1);
    chk("resume_commit", M8, 8'd6); drain();

    // both keys on an auto-request cycle: everything dropped
    idle(6);
    pulse(1, 1, 0, 0);
    chk("conflict_tick", T8, 8'd1); chk("conflict_pend", P8, 8'd0); chk("conflict_mode", M8, 8'd6); drain();
    pulse(0, 0, 0, 1);
    chk("conflict_commit", M8, 8'd6); chk("conflict_pend2", P8, 8'd0); drain();

    // key_next on an auto-request cycle: +1 only
    idle(6);
    pulse(1, 0, 0, 0);
    chk("next_auto_tick", T8, 8'd1); chk("next_auto_pend", P8, 8'd1); drain();
    pulse(0, 0, 0, 1);
    chk("next_auto_commit", M8, 8'd7); drain();

    // pause together with a step: both apply
    pulse(1, 0, 1, 0);
    chk("pause_step_auto", A8, 8'd0); chk("pause_step_pend", P8, 8'd1); drain();
    pulse(0, 0, 0, 1);
    chk("pause_step_commit", M8, 8'd0); drain();

    // reset with target 5 pending
    pulse(1, 0, 0, 0); pulse(0, 0, 0, 1);
    pulse(1, 0, 0, 0); pulse(1, 0, 0, 0); pulse(1, 0, 0, 0); pulse(1, 0, 0, 0);
    chk("pre_rst_mode", M8, 8'd1); chk("pre_rst_pend", P8, 8'd1); chk("pre_rst_auto", A8, 8'd0); drain();
    #2 rst_n = 1'b0;
    #1;
    chk("async_mode", M8, 8'd0); chk("async_pend", P8, 8'd0);
    chk("async_auto", A8, 8'd1); chk("async_tick", T8, 8'd0); drain();
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulse(0, 0, 0, 1);
    chk("post_rst_mode", M8, 8'd0); chk("post_rst_pend", P8, 8'd0); drain();
    idle(2);
    chk("post_rst_pend2", P8, 8'd0); drain();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/display_mode_ctrl.md
DISPLAY_MODE_CTRL -- requirements
Module: display_mode_ctrl

Interface
REQ-001 The block SHALL have parameter PIXEL_FREQUENCY, 28 bits, default 108_000000, giving pixel clock cycles per second.
REQ-002 The block SHALL have parameter DELAY, 5 bits, default 3, giving the auto-advance dwell in seconds; legal range 1..31.
REQ-003 The block SHALL have parameter NUM_MODES, 4 bits, default 8, giving the number of display modes; legal range 2..8.
REQ-004 The block SHALL have port clk_vga_display, input, 1 bit: pixel clock, the only clock.
REQ-005 The block SHALL have port rst_n_display, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port frame_start_display, input, 1 bit: one-cycle pulse at the first active pixel of each frame.
REQ-007 The block SHALL have port key_next_display, input, 1 bit: one-cycle debounced pulse requesting mode +1.
REQ-008 The block SHALL have port key_prev_display, input, 1 bit: one-cycle debounced pulse requesting mode -1.
REQ-009 The block SHALL have port key_pause_display, input, 1 bit: one-cycle pulse toggling auto/hold.
REQ-010 The block SHALL have port mode_display, output, 3 bits: committed mode select for the pattern generator.
REQ-011 The block SHALL have port auto_display, output, 1 bit: high in the AUTO state.
REQ-012 The block SHALL have port pending_display, output, 1 bit: high while a target mode differs from the committed mode and awaits a frame boundary.
REQ-013 The block SHALL have port sec_tick_display, output, 1 bit: one-cycle pulse per elapsed second.

Function
REQ-014 Prescaler: counts 0..PIXEL_FREQUENCY-1 and wraps to 0; sec_tick_display is registered high for the one cycle after the count equals PIXEL_FREQUENCY-1.
REQ-015 The FSM SHALL have exactly two states, AUTO and HOLD; key_pause_display toggles the state on the next clock edge.
REQ-016 Entering AUTO SHALL clear the prescaler and the dwell counter in the same edge.
REQ-017 In HOLD, the dwell counter SHALL hold at 0, no auto request SHALL be generated, and the prescaler SHALL keep running.
REQ-018 In AUTO, the dwell counter SHALL increment on each sec tick; on a tick with dwell equal to DELAY-1, dwell SHALL go to 0 and one auto request (+1) SHALL be raised.
REQ-019 A key_next or key_prev pulse SHALL clear the dwell counter in either state.
REQ-020 Target register: each request updates target relative to the current target, not the committed mode, so that two key_next pulses before a frame boundary yield +2.
REQ-021 Wrap rule: +1 from NUM_MODES-1 goes to 0; -1 from 0 goes to NUM_MODES-1; all arithmetic is modulo NUM_MODES.
REQ-022 If key_next and key_prev arrive in the same cycle, they SHALL cancel: target is unchanged and the auto request is also dropped.
REQ-023 If a key pulse and an auto request coincide, only the key SHALL apply (+1 or -1, never +2 or 0).
REQ-024 If key_pause coincides with a key_next or key_prev pulse, both the toggle and the step SHALL apply.
REQ-025 Commit: on a cycle with frame_start_display high, mode_display takes the registered target value on the next edge (latency 1 cycle); mode_display SHALL never change at any other time.
REQ-026 A request in the same cycle as frame_start_display SHALL update target but commit only at the following frame_start.
REQ-027 pending_display SHALL be registered and equal (target != mode_display).

Reset
REQ-028 While rst_n_display is low, the block SHALL immediately force: mode_display=0, target=0, pending_display=0, auto_display=1 (AUTO state), sec_tick_display=0, prescaler=0, dwell=0.
REQ-029 Reset SHALL discard any pending request, including one asserted mid-operation, with no partial commit.

Verification
REQ-030 Auto cycling, PIXEL_FREQUENCY=4, DELAY=2, frame_start every 20 cycles -> sec_tick every 4 cycles, pending=1 after the 2nd tick, mode 0->1 one cycle after the next frame_start.
REQ-031 Wrap: key_prev at mode 0, then frame_start -> mode=7 with NUM_MODES=8, and mode=4 with NUM_MODES=5; key_next at mode 7 (NUM_MODES=8) -> 0.
REQ-032 Accumulation: two key_next pulses between frames from mode 2 -> pending=1 between them and mode=4 at a single commit; key_next then key_prev -> pending returns to 0 and mode stays 2.
REQ-033 Conflict: key_next and key_prev in the same cycle as an auto request -> target, pending and mode are unchanged; key_next coinciding with an auto request -> +1 only.
REQ-034 Pause: key_pause -> auto_display=0 and no mode change over 100 cycles; second key_pause -> auto_display=1 and the first auto request exactly DELAY*PIXEL_FREQUENCY cycles later.
REQ-035 Reset while pending=1 with target=5 -> all outputs at reset values asynchronously; after release, mode=0 and pending=0 through the next frame_start.
